// File: rtl/multicycle_core_if.sv
// Shared instruction/data memory bus for multicycle_core.
// The core drives the request side through the master modport; a memory
// model or arbiter answers through the slave modport.
interface multicycle_core_if #(
  parameter int XLEN = 32
) ();

  logic            mem_req_out;
  logic            mem_we_out;
  logic [XLEN-1:0] mem_addr_out;
  logic [XLEN-1:0] mem_wdata_out;
  logic [XLEN-1:0] mem_rdata_in;
  logic            mem_ready_in;

  modport master (
    output mem_req_out,
    output mem_we_out,
    output mem_addr_out,
    output mem_wdata_out,
    input  mem_rdata_in,
    input  mem_ready_in
  );

  modport slave (
    input  mem_req_out,
    input  mem_we_out,
    input  mem_addr_out,
    input  mem_wdata_out,
    output mem_rdata_in,
    output mem_ready_in
  );

endinterface

// File: rtl/multicycle_core.sv
// Multi-cycle MIPS-subset core. One FSM walks each instruction through
// FETCH, DECODE, EXEC, MEM and WB over a single shared memory port with a
// req/ready handshake. HALT (all-zero instruction) and FAULT (bad opcode,
// misaligned load/store, memory timeout) are sticky until reset.
module multicycle_core #(
  parameter int          XLEN           = 32,
  parameter logic [31:0] PC_START       = 32'h003FFFFC,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  multicycle_core_if.master    memBus,
  output logic                 halted_out,
  output logic                 fault_out,
  output logic [XLEN-1:0]      pc_out,
  output logic [31:0]          retired_out
);

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT,
    FAULT
  } state_t;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  localparam logic [XLEN-1:0] PcReset     = XLEN'(PC_START);
  localparam bit              TimeoutOn   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0]     TimeoutLast = 32'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [XLEN-1:0]   ea_q, ea_d;
  logic [XLEN-1:0]   storeData_q, storeData_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [31:0]       retired_q, retired_d;
  logic [31:0]       timeoutCnt_q, timeoutCnt_d;
  logic              halted_q;
  logic              fault_q;
  logic [XLEN-1:0]   regFile_q [32];

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [XLEN-1:0]   immExt;
  logic [XLEN-1:0]   rsVal;
  logic [XLEN-1:0]   rtVal;
  logic [XLEN-1:0]   effAddr;
  logic              legal;
  logic              reqActive;
  logic              timeoutHit;
  logic              retire;
  logic              rfWe;
  logic [4:0]        rfAddr;
  logic [XLEN-1:0]   rfData;

  assign opcode   = ir_q[31:26];
  assign funct    = ir_q[5:0];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign immExt   = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};
  assign rsVal    = (rs == 5'd0) ? '0 : regFile_q[rs];
  assign rtVal    = (rt == 5'd0) ? '0 : regFile_q[rt];
  assign effAddr  = rsVal + immExt;

  assign reqActive  = (state_q == FETCH) || (state_q == MEM);
  assign timeoutHit = TimeoutOn && reqActive && !memBus.mem_ready_in &&
                      (timeoutCnt_q == TimeoutLast);

  // Classify the instruction register as supported or not.
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OpRType: legal = (funct == FnAdd) || (funct == FnSub) || (funct == FnAnd) ||
                       (funct == FnOr)  || (funct == FnSlt);
      OpAddi, OpLw, OpSw, OpBeq, OpBne, OpJ: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // Next-state, datapath updates, register-file write and retire decision.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    ea_d        = ea_q;
    storeData_d = storeData_q;
    result_d    = result_q;
    retire      = 1'b0;
    rfWe        = 1'b0;
    rfAddr      = 5'd0;
    rfData      = result_q;

    case (state_q)
      FETCH: begin
        if (memBus.mem_ready_in) begin
          ir_d    = memBus.mem_rdata_in[31:0];
          pc_d    = pc_q + XLEN'(4);
          state_d = DECODE;
        end else if (timeoutHit) begin
          state_d = FAULT;
        end
      end

      DECODE: begin
        if (ir_q == 32'd0) begin
          state_d = HALT;
        end else if (!legal) begin
          state_d = FAULT;
        end else begin
          state_d = EXEC;
        end
      end

      EXEC: begin
        case (opcode)
          OpRType: begin
            case (funct)
              FnAdd:   result_d = rsVal + rtVal;
              FnSub:   result_d = rsVal - rtVal;
              FnAnd:   result_d = rsVal & rtVal;
              FnOr:    result_d = rsVal | rtVal;
              default: result_d = {{(XLEN-1){1'b0}}, ($signed(rsVal) < $signed(rtVal))};
            endcase
            state_d = WB;
          end
          OpAddi: begin
            result_d = rsVal + immExt;
            state_d  = WB;
          end
          OpBeq, OpBne: begin
            if ((rsVal == rtVal) == (opcode == OpBeq)) begin
              pc_d = pc_q + (immExt << 2);
            end
            retire  = 1'b1;
            state_d = FETCH;
          end
          OpJ: begin
            pc_d    = {pc_q[XLEN-1:28], ir_q[25:0], 2'b00};
            retire  = 1'b1;
            state_d = FETCH;
          end
          OpLw, OpSw: begin
            if (effAddr[1:0] != 2'b00) begin
              state_d = FAULT;
            end else begin
              ea_d        = effAddr;
              storeData_d = rtVal;
              state_d     = MEM;
            end
          end
          default: state_d = FAULT;
        endcase
      end

      MEM: begin
        if (memBus.mem_ready_in) begin
          if (opcode == OpLw) begin
            result_d = memBus.mem_rdata_in;
            state_d  = WB;
          end else begin
            retire  = 1'b1;
            state_d = FETCH;
          end
        end else if (timeoutHit) begin
          state_d = FAULT;
        end
      end

      WB: begin
        rfWe    = 1'b1;
        rfAddr  = (opcode == OpRType) ? rd : rt;
        rfData  = result_q;
        retire  = 1'b1;
        state_d = FETCH;
      end

      HALT:    state_d = HALT;
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase

    retired_d    = retire ? (retired_q + 32'd1) : retired_q;
    timeoutCnt_d = (reqActive && !memBus.mem_ready_in) ? (timeoutCnt_q + 32'd1) : 32'd0;
  end

  // Bus outputs follow the registered state; reset forces them low at once.
  always_comb begin
    memBus.mem_req_out   = 1'b0;
    memBus.mem_we_out    = 1'b0;
    memBus.mem_addr_out  = '0;
    memBus.mem_wdata_out = '0;
    if (reqActive && !reset) begin
      memBus.mem_req_out = 1'b1;
      if (state_q == FETCH) begin
        memBus.mem_addr_out = pc_q;
      end else begin
        memBus.mem_addr_out = ea_q;
        if (opcode == OpSw) begin
          memBus.mem_we_out    = 1'b1;
          memBus.mem_wdata_out = storeData_q;
        end
      end
    end
  end

  // Core state registers, including the sticky halt/fault flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= PcReset;
      ir_q         <= '0;
      ea_q         <= '0;
      storeData_q  <= '0;
      result_q     <= '0;
      retired_q    <= '0;
      timeoutCnt_q <= '0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      ea_q         <= ea_d;
      storeData_q  <= storeData_d;
      result_q     <= result_d;
      retired_q    <= retired_d;
      timeoutCnt_q <= timeoutCnt_d;
      halted_q     <= (state_d == HALT);
      fault_q      <= (state_d == FAULT);
    end
  end

  // Register file; r0 is never written so it always reads zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regFile_q[i] <= '0;
      end
    end else if (rfWe && (rfAddr != 5'd0)) begin
      regFile_q[rfAddr] <= rfData;
    end
  end

  assign halted_out  = halted_q;
  assign fault_out   = fault_q;
  assign pc_out      = pc_q;
  assign retired_out = retired_q;

endmodule

// File: tb/tb_multicycle_core.sv
// Directed testbench for multicycle_core: a memory model answers the shared
// bus, small programs are loaded per scenario and results are compared
// against hand-computed values.
module tb_multicycle_core;

  localparam logic [31:0] PcStart = 32'h003FFFFC;

  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpBne  = 6'b000101;

  logic        clock;
  logic        reset;
  logic        halted_out;
  logic        fault_out;
  logic [31:0] pc_out;
  logic [31:0] retired_out;

  multicycle_core_if #(.XLEN(32)) bus ();

  multicycle_core #(
    .XLEN(32),
    .PC_START(32'h003FFFFC),
    .TIMEOUT_CYCLES(255)
  ) dut (
    .clock(clock),
    .reset(reset),
    .memBus(bus),
    .halted_out(halted_out),
    .fault_out(fault_out),
    .pc_out(pc_out),
    .retired_out(retired_out)
  );

  logic [31:0] mem [logic [31:0]];
  logic [31:0] readLog [64];
  int          readCount;
  int          writeCount;
  int          reqCycles;
  logic [31:0] lastWAddr;
  logic [31:0] lastWData;
  logic        holdLow;

  int checkCount;
  int errorCount;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'd0;
  endfunction

  function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] encR(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] encJ(input logic [25:0] target);
    return {6'b000010, target};
  endfunction

  // Memory responder: decides ready on the falling edge so the core sees a
  // stable answer at the next rising edge, and logs every transfer.
  always @(negedge clock) begin
    if (bus.mem_req_out) begin
      reqCycles++;
      if (!holdLow) begin
        bus.mem_ready_in = 1'b1;
        if (bus.mem_we_out) begin
          mem[bus.mem_addr_out] = bus.mem_wdata_out;
          lastWAddr = bus.mem_addr_out;
          lastWData = bus.mem_wdata_out;
          writeCount++;
          bus.mem_rdata_in = 32'd0;
        end else begin
          bus.mem_rdata_in = memRead(bus.mem_addr_out);
          if (readCount < 64) readLog[readCount] = bus.mem_addr_out;
          readCount++;
        end
      end else begin
        bus.mem_ready_in = 1'b0;
      end
    end else begin
      bus.mem_ready_in = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic putWord(input int idx, input logic [31:0] word);
    mem[PcStart + 32'(idx * 4)] = word;
  endtask

  // Hold reset for two edges, clear the logs and release just after an edge.
  task automatic applyStimulus();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    readCount  = 0;
    writeCount = 0;
    reqCycles  = 0;
    lastWAddr  = 32'hDEADBEEF;
    lastWData  = 32'hDEADBEEF;
    reset = 1'b0;
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic waitDone(input int budget, output int cycles);
    cycles = 0;
    while (!(halted_out || fault_out) && cycles < budget) begin
      @(posedge clock);
      #1;
      cycles++;
    end
    checkOutput("doneWithinBudget", {63'd0, halted_out | fault_out}, 64'd1);
  endtask

  initial begin
    int cycles;
    int stable;
    checkCount = 0;
    errorCount = 0;
    holdLow    = 1'b0;
    reset      = 1'b1;
    readCount  = 0;
    writeCount = 0;
    reqCycles  = 0;

    // Reset values while reset is held.
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rstReq",     {63'd0, bus.mem_req_out}, 64'd0);
    checkOutput("rstWe",      {63'd0, bus.mem_we_out}, 64'd0);
    checkOutput("rstAddr",    64'(bus.mem_addr_out), 64'd0);
    checkOutput("rstWdata",   64'(bus.mem_wdata_out), 64'd0);
    checkOutput("rstHalted",  {63'd0, halted_out}, 64'd0);
    checkOutput("rstFault",   {63'd0, fault_out}, 64'd0);
    checkOutput("rstPc",      64'(pc_out), 64'h003FFFFC);
    checkOutput("rstRetired", 64'(retired_out), 64'd0);

    // addi then halt.
    mem.delete();
    putWord(0, encI(OpAddi, 5'd0, 5'd1, 16'd5));
    putWord(1, 32'd0);
    applyStimulus();
    waitDone(100, cycles);
    checkOutput("haltCycles",  64'(cycles), 64'd6);
    checkOutput("haltR1",      64'(dut.regFile_q[1]), 64'd5);
    checkOutput("haltRetired", 64'(retired_out), 64'd1);
    checkOutput("haltFlag",    {63'd0, halted_out}, 64'd1);
    checkOutput("haltNoFault", {63'd0, fault_out}, 64'd0);
    checkOutput("haltPc",      64'(pc_out), 64'h00400004);
    reqCycles = 0;
    runCycles(10);
    checkOutput("haltNoReq",   64'(reqCycles), 64'd0);
    checkOutput("haltPcFrozen", 64'(pc_out), 64'h00400004);

    // addi / sw / lw / sub round trip through memory.
    mem.delete();
    putWord(0, encI(OpAddi, 5'd0, 5'd1, 16'd7));
    putWord(1, encI(OpSw, 5'd0, 5'd1, 16'd16));
    putWord(2, encI(OpLw, 5'd0, 5'd2, 16'd16));
    putWord(3, encR(5'd2, 5'd1, 5'd3, 6'b100010));
    putWord(4, 32'd0);
    applyStimulus();
    waitDone(200, cycles);
    checkOutput("memCycles",    64'(cycles), 64'd19);
    checkOutput("memWrites",    64'(writeCount), 64'd1);
    checkOutput("memWAddr",     64'(lastWAddr), 64'h10);
    checkOutput("memWData",     64'(lastWData), 64'd7);
    checkOutput("memR2",        64'(dut.regFile_q[2]), 64'd7);
    checkOutput("memR3",        64'(dut.regFile_q[3]), 64'd0);
    checkOutput("memRetired",   64'(retired_out), 64'd4);

    // ALU operations with a negative operand.
    mem.delete();
    putWord(0, encI(OpAddi, 5'd0, 5'd1, 16'hFFFD));
    putWord(1, encI(OpAddi, 5'd0, 5'd2, 16'd5));
    putWord(2, encR(5'd1, 5'd2, 5'd3, 6'b101010));
    putWord(3, encR(5'd2, 5'd1, 5'd4, 6'b101010));
    putWord(4, encR(5'd1, 5'd2, 5'd5, 6'b100100));
    putWord(5, encR(5'd1, 5'd2, 5'd6, 6'b100101));
    putWord(6, encR(5'd1, 5'd2, 5'd7, 6'b100000));
    putWord(7, encR(5'd0, 5'd2, 5'd8, 6'b100010));
    putWord(8, 32'd0);
    applyStimulus();
    waitDone(300, cycles);
    checkOutput("aluCycles",  64'(cycles), 64'd34);
    checkOutput("aluR1",      64'(dut.regFile_q[1]), 64'hFFFFFFFD);
    checkOutput("aluSltLt",   64'(dut.regFile_q[3]), 64'd1);
    checkOutput("aluSltGe",   64'(dut.regFile_q[4]), 64'd0);
    checkOutput("aluAnd",     64'(dut.regFile_q[5]), 64'd5);
    checkOutput("aluOr",      64'(dut.regFile_q[6]), 64'hFFFFFFFD);
    checkOutput("aluAdd",     64'(dut.regFile_q[7]), 64'd2);
    checkOutput("aluSubWrap", 64'(dut.regFile_q[8]), 64'hFFFFFFFB);
    checkOutput("aluRetired", 64'(retired_out), 64'd8);

    // Taken beq skips two words.
    mem.delete();
    putWord(0, encI(OpBeq, 5'd0, 5'd0, 16'd2));
    applyStimulus();
    waitDone(100, cycles);
    checkOutput("beqCycles",   64'(cycles), 64'd5);
    checkOutput("beqTarget",   64'(readLog[1]), 64'h00400008);
    checkOutput("beqRetired",  64'(retired_out), 64'd1);

    // Not-taken bne falls through into a jump-to-self loop.
    mem.delete();
    putWord(0, encI(OpBne, 5'd0, 5'd0, 16'd2));
    putWord(1, encJ(26'h0100000));
    applyStimulus();
    runCycles(12);
    checkOutput("bneFall",     64'(readLog[1]), 64'h00400000);
    checkOutput("jTarget1",    64'(readLog[2]), 64'h00400000);
    checkOutput("jTarget2",    64'(readLog[3]), 64'h00400000);
    checkOutput("jFetches",    64'(readCount), 64'd4);
    checkOutput("jRetired",    64'(retired_out), 64'd4);

    // Fetch stalled for 10 cycles keeps the request stable.
    mem.delete();
    putWord(0, encI(OpAddi, 5'd0, 5'd1, 16'd5));
    holdLow = 1'b1;
    applyStimulus();
    stable = 0;
    repeat (10) begin
      @(posedge clock);
      #1;
      if (bus.mem_req_out && !bus.mem_we_out && bus.mem_addr_out == PcStart) stable++;
    end
    checkOutput("stallStable", 64'(stable), 64'd10);
    holdLow = 1'b0;
    waitDone(100, cycles);
    checkOutput("stallR1",     64'(dut.regFile_q[1]), 64'd5);
    checkOutput("stallNoFault", {63'd0, fault_out}, 64'd0);
    checkOutput("stallRetired", 64'(retired_out), 64'd1);

    // Fetch stalled until the timeout fires.
    holdLow = 1'b1;
    applyStimulus();
    runCycles(254);
    checkOutput("toBeforeFault", {63'd0, fault_out}, 64'd0);
    checkOutput("toBeforeReq",   {63'd0, bus.mem_req_out}, 64'd1);
    runCycles(1);
    checkOutput("toFault",       {63'd0, fault_out}, 64'd1);
    checkOutput("toReqDropped",  {63'd0, bus.mem_req_out}, 64'd0);
    holdLow = 1'b0;
    reqCycles = 0;
    runCycles(5);
    checkOutput("toSticky",      {63'd0, fault_out}, 64'd1);
    checkOutput("toNoReq",       64'(reqCycles), 64'd0);
    checkOutput("toPc",          64'(pc_out), 64'h003FFFFC);
    checkOutput("toRetired",     64'(retired_out), 64'd0);

    // Misaligned load faults without a data-phase request.
    mem.delete();
    putWord(0, encI(OpLw, 5'd0, 5'd1, 16'd2));
    applyStimulus();
    waitDone(100, cycles);
    runCycles(5);
    checkOutput("misFault",    {63'd0, fault_out}, 64'd1);
    checkOutput("misCycles",   64'(cycles), 64'd3);
    checkOutput("misReqs",     64'(reqCycles), 64'd1);
    checkOutput("misHalted",   {63'd0, halted_out}, 64'd0);

    // Unsupported opcode faults and does not retire.
    mem.delete();
    putWord(0, encI(OpAddi, 5'd0, 5'd1, 16'd5));
    putWord(1, 32'hFC000000);
    applyStimulus();
    waitDone(100, cycles);
    checkOutput("badFault",    {63'd0, fault_out}, 64'd1);
    checkOutput("badCycles",   64'(cycles), 64'd6);
    checkOutput("badRetired",  64'(retired_out), 64'd1);
    checkOutput("badPc",       64'(pc_out), 64'h00400004);

    // Reset asserted during a stalled load.
    mem.delete();
    putWord(0, encI(OpAddi, 5'd0, 5'd1, 16'd7));
    putWord(1, encI(OpLw, 5'd0, 5'd2, 16'd16));
    applyStimulus();
    runCycles(6);
    holdLow = 1'b1;
    runCycles(3);
    checkOutput("stallMemReq",  {63'd0, bus.mem_req_out}, 64'd1);
    checkOutput("stallMemAddr", 64'(bus.mem_addr_out), 64'h10);
    checkOutput("stallMemR1",   64'(dut.regFile_q[1]), 64'd7);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("asyncReqDrop", {63'd0, bus.mem_req_out}, 64'd0);
    checkOutput("asyncPc",      64'(pc_out), 64'h003FFFFC);
    checkOutput("asyncR1",      64'(dut.regFile_q[1]), 64'd0);
    holdLow = 1'b0;
    applyStimulus();
    waitDone(100, cycles);
    checkOutput("restartFetch", 64'(readLog[0]), 64'h003FFFFC);
    checkOutput("restartR1",    64'(dut.regFile_q[1]), 64'd7);
    checkOutput("restartHalt",  {63'd0, halted_out}, 64'd1);

    // Writes to r0 are discarded.
    mem.delete();
    putWord(0, encI(OpAddi, 5'd0, 5'd0, 16'd9));
    putWord(1, encI(OpSw, 5'd0, 5'd0, 16'd32));
    applyStimulus();
    waitDone(100, cycles);
    checkOutput("r0Cycles",    64'(cycles), 64'd10);
    checkOutput("r0StoreAddr", 64'(lastWAddr), 64'h20);
    checkOutput("r0StoreData", 64'(lastWData), 64'd0);
    checkOutput("r0Reg",       64'(dut.regFile_q[0]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/multicycle_core.md
Name: multicycle_core

Overview:
- Parametrised multi-cycle successor to the single-cycle datapath; one FSM sequences fetch, decode, execute, memory and writeback.
- Single shared instruction/data memory port with a req/ready handshake, so memory may stall for any number of cycles.
- Applies branch/jump results to the PC, detects halt, misaligned access and memory timeout, and counts retired instructions.

Parameters:
- XLEN, 32, datapath/register/PC width; legal values 32 or 64; instructions always 32 bits taken from mem_rdata_in[31:0].
- PC_START, 32'h003FFFFC, PC value after reset, zero-extended to XLEN.
- TIMEOUT_CYCLES, 255, maximum stall cycles with req high and ready low before FAULT; 0 disables the timeout.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- mem_req_out  out  1  memory request valid.
- mem_we_out  out  1  1 = write, 0 = read; valid only while mem_req_out=1.
- mem_addr_out  out  XLEN  byte address, word-aligned.
- mem_wdata_out  out  XLEN  store data.
- mem_rdata_in  in  XLEN  read data, sampled on the edge where mem_ready_in=1.
- mem_ready_in  in  1  request accepted/completed this cycle.
- halted_out  out  1  core in HALT.
- fault_out  out  1  core in FAULT.
- pc_out  out  XLEN  current PC.
- retired_out  out  32  retired-instruction count, wraps.

Behaviour:
- Reset values: pc=PC_START, state=FETCH, all 32 registers=0, ir=0.
- Reset values: mem_req_out=0, mem_we_out=0, mem_addr_out=0, mem_wdata_out=0, halted_out=0, fault_out=0, retired_out=0, timeout counter=0.
- Reset asserted mid-operation drops mem_req_out immediately, with no cycle wait.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT.
- Handshake: req/we/addr/wdata stay stable from assertion until the edge where ready=1. Transfer completes on that edge. req deasserts in the following state unless a new request starts. Ready while req=0 is ignored.
- FETCH: req=1, we=0, addr=pc. On ready: ir<=rdata[31:0], pc<=pc+4, go to DECODE.
- DECODE: read rs=ir[25:21] and rt=ir[20:16]; sign-extend ir[15:0] to XLEN.
  - ir==0 → HALT.
  - Unsupported opcode/funct → FAULT.
  - Otherwise → EXEC.
- Supported instructions:
  - R-type (op 000000): add 100000, sub 100010, and 100100, or 100101, slt 101010.
  - I-type: addi 001000, lw 100011, sw 101011, beq 000100, bne 000101.
  - J-type: j 000010.
- EXEC, R-type/addi: result computed, go to WB.
  - add/sub wrap mod 2^XLEN; slt signed, result 0 or 1.
- EXEC, beq/bne: if taken, pc<=pc+(sext(imm)<<2); otherwise PC unchanged. Retire, go to FETCH.
- EXEC, j: pc<={pc[XLEN-1:28], ir[25:0], 2'b00}. Retire, go to FETCH.
- EXEC, lw/sw: effective address ea=rs+sext(imm). If ea[1:0]!=0, go to FAULT with no request issued; otherwise go to MEM.
- MEM: req=1, addr=ea, we=1 for sw, wdata=rt.
  - lw on ready: latch rdata, go to WB.
  - sw on ready: retire, go to FETCH.
- WB: write dest register; go to FETCH and retire.
  - Dest is rd=ir[15:11] for R-type, rt for addi/lw.
  - Writes to r0 are discarded; r0 always reads 0.
- Timeout: counter increments each cycle req=1 and ready=0, and clears on ready or when req=0. When TIMEOUT_CYCLES!=0 and the count reaches TIMEOUT_CYCLES, go to FAULT and drop req next cycle.
- HALT and FAULT are sticky until reset. No requests issued; pc and retired_out frozen. halted_out/fault_out are registered and high exactly while in the respective state.
- Retire: retired_out+=1 on the edge leaving the final state of each instruction; 32'hFFFFFFFF wraps to 0. HALT/FAULT instructions do not retire.
- Latency with zero-wait memory (ready high same cycle as req): R/addi 4 cycles, branch/j 3, sw 4, lw 5.

Test Plan:
- Reset, memory holds addi r1,r0,5 at 0x003FFFFC then 0 at 0x00400000 → r1=5, retired_out=1, halted_out=1, pc_out=0x00400004, no further req.
- Program addi r1,r0,7; sw r1,16(r0); lw r2,16(r0); sub r3,r2,r1 → write of addr 0x10 data 7, r2=7, r3=0, retired_out=4.
- beq r0,r0,+2 at PC P → next fetch address P+12; bne r0,r0,+2 → next fetch P+4; j 0x0100000 from 0x00400000 → fetch 0x00400000.
- ready held low 10 cycles during fetch with TIMEOUT_CYCLES=255 → req/addr stable all 10 cycles, completes normally. ready held low 255 cycles → fault_out=1, req=0.
- lw r1,2(r0) → fault_out=1, no data-phase req issued. Opcode 111111 → fault_out=1, retired_out unchanged.
- Assert reset during a MEM stall → req drops asynchronously; after release pc=PC_START, registers 0, fetch restarts. addi r0,r0,9 → r0 reads 0.
